// File: rtl/corr_lag_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : corr_lag_accumulator
// Purpose : Per-lag multiply-accumulate of delayed-sample bursts into a bin
//           RAM, followed by an in-order, clear-on-read frame dump.
// Rev     : 1.0  initial release
// ============================================================================
module corr_lag_accumulator #(
    parameter int AW    = 9,
    parameter int ACC_W = 32,
    parameter int NSAMP = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [7:0]       din,
    input  logic [7:0]       dshift,
    input  logic             dvalid,
    output logic [ACC_W-1:0] res_data,
    output logic [AW-1:0]    res_lag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             drop_flag,
    output logic             sat_flag
);

    localparam logic [1:0]    ST_CLEAR  = 2'd0;
    localparam logic [1:0]    ST_ACC    = 2'd1;
    localparam logic [1:0]    ST_DRAIN  = 2'd2;
    localparam logic [1:0]    ST_DUMP   = 2'd3;
    localparam int            SW        = ACC_W + 1;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [15:0]   BCNT_LAST = 16'(NSAMP - 1);

    logic [1:0]       r_state;
    logic [AW-1:0]    r_sweep;
    logic [AW-1:0]    r_lag;
    logic [AW-1:0]    r_dump_addr;
    logic [15:0]      r_bcnt;
    logic [1:0]       r_drain_cnt;
    logic [7:0]       r_x;
    logic             r_beat_d;
    logic             r_pend;

    logic             r_v1, r_v2, r_v3;
    logic [AW-1:0]    r_a1, r_a2, r_a3;
    logic [15:0]      r_p1;
    logic [ACC_W-1:0] r_w2, r_w3;
    logic             r_sat2;

    logic [ACC_W-1:0] r_mem [0:(1 << AW) - 1];
    logic [ACC_W-1:0] r_rd;

    logic             w_beat, w_first, w_burst_end, w_accept;
    logic [AW-1:0]    w_lag_cur, w_raddr, w_waddr;
    logic [7:0]       w_x;
    logic [ACC_W-1:0] w_acc, w_clamped, w_wdata;
    logic [SW-1:0]    w_sum;
    logic             w_we;

    assign busy        = (r_state != ST_ACC);
    assign w_beat      = dvalid && (r_state == ST_ACC);
    assign w_first     = w_beat && !r_beat_d;
    assign w_burst_end = (r_state == ST_ACC) && !w_beat && r_beat_d;
    assign w_lag_cur   = w_first ? '0 : r_lag;
    assign w_x         = w_first ? din : r_x;
    assign w_accept    = (r_state == ST_DUMP) && res_valid && res_ready;

    // The S3 entry retires on the same edge the S1 read samples the RAM, so
    // both younger write-backs must be forwarded; the newest one wins.
    always_comb begin
        w_acc = r_rd;
        if (r_v3 && (r_a3 == r_a1)) w_acc = r_w3;
        if (r_v2 && (r_a2 == r_a1)) w_acc = r_w2;
        w_sum     = {1'b0, w_acc} + SW'(r_p1);
        w_clamped = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    end

    always_comb begin
        w_raddr = w_lag_cur;
        if (r_state == ST_DRAIN)
            w_raddr = '0;
        else if (r_state == ST_DUMP)
            w_raddr = w_accept ? (r_dump_addr + AW'(1)) : r_dump_addr;
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_sweep;
        end else if (r_v2) begin
            w_we    = 1'b1;
            w_waddr = r_a2;
            w_wdata = r_w2;
        end else if (w_accept) begin
            w_we    = 1'b1;
            w_waddr = res_lag;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rd <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= w_beat;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
        r_a1   <= w_lag_cur;
        r_p1   <= 16'(w_x) * 16'(dshift);
        r_a2   <= r_a1;
        r_w2   <= w_clamped;
        r_sat2 <= r_v1 && w_sum[ACC_W];
        r_a3   <= r_a2;
        r_w3   <= r_w2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state     <= ST_CLEAR;
            r_sweep     <= '0;
            r_lag       <= '0;
            r_bcnt      <= '0;
            r_drain_cnt <= '0;
            r_dump_addr <= '0;
            r_x         <= '0;
            r_beat_d    <= 1'b0;
            r_pend      <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_lag     <= '0;
            frame_done  <= 1'b0;
            drop_flag   <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            r_beat_d   <= w_beat;
            if (dvalid && (r_state != ST_ACC)) drop_flag <= 1'b1;
            if (r_v2 && r_sat2) sat_flag <= 1'b1;

            case (r_state)
                ST_CLEAR: begin
                    r_sweep <= r_sweep + AW'(1);
                    if (r_sweep == LAST_ADDR) begin
                        r_state  <= ST_ACC;
                        sat_flag <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (w_beat) begin
                        r_lag <= w_lag_cur + AW'(1);
                        r_x   <= w_x;
                    end
                    if (w_burst_end) begin
                        r_bcnt <= r_bcnt + 16'd1;
                        if (r_bcnt == BCNT_LAST) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                    if (r_drain_cnt == 2'd2) begin
                        r_state     <= ST_DUMP;
                        r_dump_addr <= '0;
                        r_pend      <= 1'b1;
                    end
                end
                default: begin
                    // r_pend marks that r_rd holds the bin at r_dump_addr.
                    if (r_pend) begin
                        res_valid <= 1'b1;
                        res_data  <= r_rd;
                        res_lag   <= r_dump_addr;
                        r_pend    <= 1'b0;
                    end else if (w_accept) begin
                        res_valid <= 1'b0;
                        if (res_lag == LAST_ADDR) begin
                            frame_done <= 1'b1;
                            r_bcnt     <= '0;
                            r_state    <= ST_ACC;
                            sat_flag   <= 1'b0;
                        end else begin
                            r_dump_addr <= r_dump_addr + AW'(1);
                            r_pend      <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_corr_lag_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_corr_lag_accumulator
// Purpose : Scoreboard bench for corr_lag_accumulator (two parameterisations).
// Rev     : 1.0  initial release
// ============================================================================
module tb_corr_lag_accumulator;

    localparam int NB = 512;

    typedef struct packed {
        logic [8:0]  lag;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clr       [2];
    logic [7:0]  din       [2];
    logic [7:0]  dshift    [2];
    logic        dvalid    [2];
    logic        res_ready [2];
    logic [31:0] res_data  [2];
    logic [8:0]  res_lag   [2];
    logic        res_valid [2];
    logic        busy      [2];
    logic        frame_done[2];
    logic        drop_flag [2];
    logic        sat_flag  [2];
    logic [31:0] res_data_a;
    logic [15:0] res_data_b;

    int          n_checks;
    int          n_fail;
    int unsigned model [2][NB];
    bit          msat  [2];
    exp_t        exp_q [$];
    logic [7:0]  ds_q  [$];

    assign res_data[0] = res_data_a;
    assign res_data[1] = {16'd0, res_data_b};

    corr_lag_accumulator #(.AW(9), .ACC_W(32), .NSAMP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .din(din[0]), .dshift(dshift[0]),
        .dvalid(dvalid[0]), .res_data(res_data_a), .res_lag(res_lag[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .drop_flag(drop_flag[0]), .sat_flag(sat_flag[0])
    );

    corr_lag_accumulator #(.AW(9), .ACC_W(16), .NSAMP(2)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .din(din[1]), .dshift(dshift[1]),
        .dvalid(dvalid[1]), .res_data(res_data_b), .res_lag(res_lag[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .drop_flag(drop_flag[1]), .sat_flag(sat_flag[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_add(input int idx, input int lag, input int unsigned p);
        longint unsigned s;
        longint unsigned lim;
        lim = (idx == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
        s   = longint'(model[idx][lag]) + longint'(p);
        if (s > lim) begin
            s         = lim;
            msat[idx] = 1'b1;
        end
        model[idx][lag] = 32'(s);
    endtask

    // Drives one burst from ds_q; din carries x only on the first beat.
    task automatic drive_burst(input int idx, input logic [7:0] x, input bit upd);
        for (int k = 0; k < ds_q.size(); k++) begin
            @(negedge clk);
            dvalid[idx] = 1'b1;
            din[idx]    = (k == 0) ? x : 8'($urandom);
            dshift[idx] = ds_q[k];
            if (upd) model_add(idx, k % NB, 32'(x) * 32'(ds_q[k]));
        end
        @(negedge clk);
        dvalid[idx] = 1'b0;
        din[idx]    = 8'd0;
        dshift[idx] = 8'd0;
    endtask

    task automatic wait_clear(input int idx, input string name);
        int cnt;
        cnt = 0;
        while (busy[idx] === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != NB) begin
            n_fail++;
            $display("FAIL %s: busy lasted %0d cycles, required %0d", name, cnt, NB);
        end
    endtask

    task automatic run_dump(input int idx, input bit rnd, input int stop_lag);
        exp_t        e;
        int          got, cyc, fd;
        bit          pv, pr;
        logic [31:0] pd;
        logic [8:0]  pl;
        got = 0; cyc = 0; fd = 0; pv = 1'b0; pr = 1'b0; pd = '0; pl = '0;
        for (int l = 0; l < NB; l++) begin
            e.lag  = 9'(l);
            e.data = model[idx][l];
            exp_q.push_back(e);
            model[idx][l] = 0;
        end
        res_ready[idx] = 1'b0;
        while (got < NB && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (frame_done[idx] === 1'b1) fd++;
            if (pv && !pr) begin
                n_checks++;
                if (res_valid[idx] !== 1'b1 || res_data[idx] !== pd || res_lag[idx] !== pl) begin
                    n_fail++;
                    $display("FAIL stall_hold dut%0d: valid=%0b lag=%0d data=%0d, required valid=1 lag=%0d data=%0d",
                             idx, res_valid[idx], res_lag[idx], res_data[idx], pl, pd);
                end
            end
            if (res_valid[idx] === 1'b1 && stop_lag >= 0 && int'(res_lag[idx]) == stop_lag) begin
                res_ready[idx] = 1'b0;
                return;
            end
            res_ready[idx] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pv = (res_valid[idx] === 1'b1);
            pr = res_ready[idx];
            pd = res_data[idx];
            pl = res_lag[idx];
            if (pv && pr) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dump_word dut%0d: unexpected word lag=%0d data=%0d, required none",
                             idx, res_lag[idx], res_data[idx]);
                end else begin
                    e = exp_q.pop_front();
                    if (res_lag[idx] !== e.lag || res_data[idx] !== e.data) begin
                        n_fail++;
                        $display("FAIL dump_word dut%0d: lag=%0d data=%0d, required lag=%0d data=%0d",
                                 idx, res_lag[idx], res_data[idx], e.lag, e.data);
                    end
                end
                got++;
            end
        end
        @(negedge clk);
        res_ready[idx] = 1'b0;
        n_checks++;
        if (got != NB) begin
            n_fail++;
            $display("FAIL dump_count dut%0d: %0d words, required %0d", idx, got, NB);
        end
        n_checks++;
        if (frame_done[idx] !== 1'b1 || fd != 0) begin
            n_fail++;
            $display("FAIL frame_done_pulse dut%0d: now=%0b early=%0d, required now=1 early=0",
                     idx, frame_done[idx], fd);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done[idx] !== 1'b0 || busy[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end dut%0d: frame_done=%0b busy=%0b, required 0 0",
                     idx, frame_done[idx], busy[idx]);
        end
        exp_q.delete();
    endtask

    task automatic check_flag(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b1 || busy[1] !== 1'b1 || res_valid[0] !== 1'b0 || res_lag[0] !== 9'd0 ||
            res_data[0] !== 32'd0 || frame_done[0] !== 1'b0 || drop_flag[0] !== 1'b0 ||
            sat_flag[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b/%0b valid=%0b lag=%0d data=%0d fd=%0b drop=%0b sat=%0b, required 1/1 0 0 0 0 0 0",
                     busy[0], busy[1], res_valid[0], res_lag[0], res_data[0], frame_done[0],
                     drop_flag[0], sat_flag[0]);
        end
        rst_n = 1'b1;
        wait_clear(0, "reset_clear_len");
        idle(2);
        check_flag("busy_after_clear", busy[0], 1'b0);
        ds_q = '{8'd0};
        drive_burst(0, 8'd0, 1'b1);
        run_dump(0, 1'b0, -1);
    endtask

    task automatic test_accumulate();
        ds_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        drive_burst(1, 8'd3, 1'b1);
        drive_burst(1, 8'd3, 1'b1);
        idle(6);
        check_flag("accumulate_sat", sat_flag[1], 1'b0);
        run_dump(1, 1'b0, -1);
    endtask

    task automatic test_saturate();
        msat[1] = 1'b0;
        ds_q = '{8'd255};
        drive_burst(1, 8'd255, 1'b1);
        drive_burst(1, 8'd255, 1'b1);
        idle(6);
        check_flag("saturate_sat", sat_flag[1], msat[1]);
        run_dump(1, 1'b0, -1);
        check_flag("saturate_sat_cleared", sat_flag[1], 1'b0);
    endtask

    task automatic test_random_ready();
        logic [7:0] x;
        x = 8'($urandom_range(1, 255));
        ds_q.delete();
        for (int k = 0; k < 520; k++) ds_q.push_back(8'($urandom));
        for (int f = 0; f < 2; f++) begin
            drive_burst(0, x, 1'b1);
            run_dump(0, 1'b1, -1);
        end
    endtask

    task automatic test_drop();
        int cyc;
        ds_q = '{8'd1, 8'd2};
        drive_burst(0, 8'd5, 1'b1);
        cyc = 0;
        while (res_valid[0] !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_flag("drop_dump_started", res_valid[0], 1'b1);
        ds_q = '{8'd9, 8'd9, 8'd9};
        drive_burst(0, 8'd7, 1'b0);
        check_flag("drop_flag_set", drop_flag[0], 1'b1);
        run_dump(0, 1'b0, -1);
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check_flag("drop_flag_clr", drop_flag[0], 1'b0);
        wait_clear(0, "clr_clear_len");
    endtask

    task automatic test_clr_mid_dump();
        ds_q.delete();
        for (int k = 0; k < 200; k++) ds_q.push_back(8'((k % 7) + 1));
        drive_burst(0, 8'd1, 1'b1);
        run_dump(0, 1'b0, 100);
        check_flag("clr_stop_at_100", res_valid[0], 1'b1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check_flag("clr_drops_valid", res_valid[0], 1'b0);
        exp_q.delete();
        for (int l = 0; l < NB; l++) model[0][l] = 0;
        wait_clear(0, "clr_mid_dump_clear_len");
        ds_q = '{8'd5};
        drive_burst(0, 8'd2, 1'b1);
        run_dump(0, 1'b0, -1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0; din[i] = 8'd0; dshift[i] = 8'd0;
            dvalid[i] = 1'b0; res_ready[i] = 1'b0; msat[i] = 1'b0;
            for (int l = 0; l < NB; l++) model[i][l] = 0;
        end
        test_reset();
        test_accumulate();
        test_saturate();
        test_random_ready();
        test_drop();
        test_clr_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
